// File: rtl/decode_writeback.sv
// Y86-64 decode stage with register file, operand forwarding and E register.
// Write-back into the register file happens on the same edge that loads E.
module decode_writeback #(
    parameter int NREG = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:3]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valc,
    input  logic [63:0] D_valP,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    input  logic        E_bubble,
    output logic [0:3]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [63:0] rf [NREG];
    logic [63:0] rf_a;
    logic [63:0] rf_b;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [63:0] d_valA;
    logic [63:0] d_valB;

    // Pick an operand: newest in-flight producer wins, then the register file.
    function automatic logic [63:0] fwd(input logic [3:0]  src,
                                        input logic [63:0] rfv);
        if (src == RNONE)       return '0;
        else if (src == e_dstE) return e_valE;
        else if (src == M_dstM) return m_valM;
        else if (src == M_dstE) return M_valE;
        else if (src == W_dstM) return W_valM;
        else if (src == W_dstE) return W_valE;
        else                    return rfv;
    endfunction

    // Register ID selection from the instruction code.
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            4'h2, 4'h4, 4'h6, 4'hA: d_srcA = D_rA;
            4'h9, 4'hB:             d_srcA = RSP;
            default:                d_srcA = RNONE;
        endcase
        case (D_icode)
            4'h4, 4'h5, 4'h6:       d_srcB = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: d_srcB = RSP;
            default:                d_srcB = RNONE;
        endcase
        case (D_icode)
            4'h2, 4'h3, 4'h6:       d_dstE = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: d_dstE = RSP;
            default:                d_dstE = RNONE;
        endcase
        case (D_icode)
            4'h5, 4'hB: d_dstM = D_rA;
            default:    d_dstM = RNONE;
        endcase
    end

    // Combinational register file read; unmatched IDs (incl. none) read 0.
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (d_srcA == 4'(i)) rf_a = rf[i];
            if (d_srcB == 4'(i)) rf_b = rf[i];
        end
    end

    // Operand values; call and jump carry valP down in valA.
    always_comb begin
        if (D_icode == 4'h7 || D_icode == 4'h8) d_valA = D_valP;
        else d_valA = fwd(d_srcA, rf_a);
        d_valB = fwd(d_srcB, rf_b);
    end

    // Register file write-back; the M port wins when both target one register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst_n) rf[i] <= '0;
            else if (W_dstM == 4'(i)) rf[i] <= W_valM;
            else if (W_dstE == 4'(i)) rf[i] <= W_valE;
        end
    end

    // E pipeline register; reset and bubble both load a nop.
    always_ff @(posedge clk) begin
        if (!rst_n || E_bubble) begin
            E_stat  <= 4'b1000;
            E_icode <= 4'h1;
            E_ifun  <= 4'h0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else begin
            E_stat  <= D_stat;
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= D_valc;
            E_valA  <= d_valA;
            E_valB  <= d_valB;
            E_dstE  <= d_dstE;
            E_dstM  <= d_dstM;
            E_srcA  <= d_srcA;
            E_srcB  <= d_srcB;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Directed vector bench for decode_writeback: decode, forwarding,
// write-back, bubble and reset behaviour.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:3]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valc, D_valP;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic        E_bubble;
    logic [0:3]  E_stat;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
    logic [3:0]  d_srcA, d_srcB;

    int n_cmp = 0;
    int n_bad = 0;

    decode_writeback #(.NREG(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valc(D_valc), .D_valP(D_valP),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .E_bubble(E_bubble),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .d_srcA(d_srcA), .d_srcB(d_srcB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  stat, icode, ifun, rA, rB;
        logic [63:0] valc, valP;
        logic [3:0]  e_dstE;  logic [63:0] e_valE;
        logic [3:0]  M_dstE;  logic [63:0] M_valE;
        logic [3:0]  M_dstM;  logic [63:0] m_valM;
        logic [3:0]  W_dstE;  logic [63:0] W_valE;
        logic [3:0]  W_dstM;  logic [63:0] W_valM;
        logic        bubble;
        logic [63:0] x_valA, x_valB;
        logic [3:0]  x_dstE, x_dstM, x_srcA, x_srcB;
    } vec_t;

    vec_t tbl[$];
    vec_t t;

    localparam logic [3:0] F = 4'hF;

    function automatic vec_t mk(input logic [3:0] icode, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [63:0] valc,
                                input logic [63:0] valp);
        vec_t v;
        v.stat = 4'b1000; v.icode = icode; v.ifun = icode ^ 4'h5;
        v.rA = ra; v.rB = rb; v.valc = valc; v.valP = valp;
        v.e_dstE = F; v.e_valE = 64'h0;
        v.M_dstE = F; v.M_valE = 64'h0;
        v.M_dstM = F; v.m_valM = 64'h0;
        v.W_dstE = F; v.W_valE = 64'h0;
        v.W_dstM = F; v.W_valM = 64'h0;
        v.bubble = 1'b0;
        v.x_valA = 64'h0; v.x_valB = 64'h0;
        v.x_dstE = F; v.x_dstM = F; v.x_srcA = F; v.x_srcB = F;
        return v;
    endfunction

    task automatic add(input vec_t v, input logic [63:0] va, input logic [63:0] vb,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [3:0] sa, input logic [3:0] sb);
        v.x_valA = va; v.x_valB = vb;
        v.x_dstE = de; v.x_dstM = dm; v.x_srcA = sa; v.x_srcB = sb;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        D_stat = v.stat; D_icode = v.icode; D_ifun = v.ifun;
        D_rA = v.rA; D_rB = v.rB; D_valc = v.valc; D_valP = v.valP;
        e_dstE = v.e_dstE; e_valE = v.e_valE;
        M_dstE = v.M_dstE; M_valE = v.M_valE;
        M_dstM = v.M_dstM; m_valM = v.m_valM;
        W_dstE = v.W_dstE; W_valE = v.W_valE;
        W_dstM = v.W_dstM; W_valM = v.W_valM;
        E_bubble = v.bubble;
    endtask

    task automatic chk_nop(input string tag);
        chk({tag, " stat"}, 64'(E_stat), 64'h8);
        chk({tag, " icode"}, 64'(E_icode), 64'h1);
        chk({tag, " ifun"}, 64'(E_ifun), 64'h0);
        chk({tag, " valC"}, E_valC, 64'h0);
        chk({tag, " valA"}, E_valA, 64'h0);
        chk({tag, " valB"}, E_valB, 64'h0);
        chk({tag, " dstE"}, 64'(E_dstE), 64'hF);
        chk({tag, " dstM"}, 64'(E_dstM), 64'hF);
        chk({tag, " srcA"}, 64'(E_srcA), 64'hF);
        chk({tag, " srcB"}, 64'(E_srcB), 64'hF);
    endtask

    initial begin
        // rrmovq r3->r7; W writes r2=5
        t = mk(4'h2, 4'h3, 4'h7, 64'h0, 64'h0);
        t.W_dstE = 4'h2; t.W_valE = 64'h5;
        add(t, 64'h0, 64'h0, 4'h7, F, 4'h3, F);
        // read back r2 written last cycle
        t = mk(4'h2, 4'h2, 4'h9, 64'h0, 64'h0);
        add(t, 64'h5, 64'h0, 4'h9, F, 4'h2, F);
        // forwarding priority e > M > W
        t = mk(4'h6, 4'h3, 4'h2, 64'h0, 64'h0);
        t.e_dstE = 4'h3; t.e_valE = 64'hAA;
        t.M_dstE = 4'h3; t.M_valE = 64'hBB;
        t.W_dstM = 4'h3; t.W_valM = 64'hCC;
        add(t, 64'hAA, 64'h5, 4'h2, F, 4'h3, 4'h2);
        t.e_dstE = F;
        add(t, 64'hBB, 64'h5, 4'h2, F, 4'h3, 4'h2);
        t.M_dstE = F;
        add(t, 64'hCC, 64'h5, 4'h2, F, 4'h3, 4'h2);
        // W forward beats stale register contents (r3=CC)
        t = mk(4'h6, 4'h3, 4'h3, 64'h0, 64'h0);
        t.W_dstM = 4'h3; t.W_valM = 64'hDD;
        add(t, 64'hDD, 64'hDD, 4'h3, F, 4'h3, 4'h3);
        // M_dstM beats M_dstE; dual write r6 (M port wins)
        t = mk(4'h4, 4'h5, 4'h6, 64'h0, 64'h0);
        t.M_dstM = 4'h5; t.m_valM = 64'h11;
        t.M_dstE = 4'h5; t.M_valE = 64'h22;
        t.e_dstE = 4'h6; t.e_valE = 64'h33;
        t.W_dstE = 4'h6; t.W_valE = 64'h1;
        t.W_dstM = 4'h6; t.W_valM = 64'h2;
        add(t, 64'h11, 64'h33, F, F, 4'h5, 4'h6);
        // r6 holds 2; write r4=0x100
        t = mk(4'h2, 4'h6, 4'h1, 64'h0, 64'h0);
        t.W_dstE = 4'h4; t.W_valE = 64'h100;
        add(t, 64'h2, 64'h0, 4'h1, F, 4'h6, F);
        // call
        t = mk(4'h8, 4'h0, 4'h0, 64'h1234, 64'h45);
        add(t, 64'h45, 64'h100, 4'h4, F, F, 4'h4);
        // nop: F sources never match F destinations
        t = mk(4'h1, 4'h2, 4'h2, 64'h0, 64'h0);
        t.e_valE = 64'h77; t.W_valE = 64'h88; t.m_valM = 64'h66;
        add(t, 64'h0, 64'h0, F, F, F, F);
        // invalid icode passes with odd stat
        t = mk(4'hC, 4'h2, 4'h2, 64'h9, 64'h0);
        t.stat = 4'b0100;
        add(t, 64'h0, 64'h0, F, F, F, F);
        // popq r8
        t = mk(4'hB, 4'h8, 4'h3, 64'h0, 64'h0);
        add(t, 64'h100, 64'h100, 4'h4, 4'h8, 4'h4, 4'h4);
        // bubble over mrmovq; W write r11 still lands
        t = mk(4'h5, 4'hA, 4'h2, 64'h10, 64'h0);
        t.bubble = 1'b1;
        t.W_dstE = 4'hB; t.W_valE = 64'h5A;
        add(t, 64'h0, 64'h5, F, 4'hA, F, 4'h2);
        t = mk(4'h2, 4'hB, 4'h0, 64'h0, 64'h0);
        add(t, 64'h5A, 64'h0, 4'h0, F, 4'hB, F);
        // mrmovq
        t = mk(4'h5, 4'hC, 4'h2, 64'h10, 64'h0);
        add(t, 64'h0, 64'h5, F, 4'hC, F, 4'h2);
        // ret with W_dstE forward of rsp
        t = mk(4'h9, 4'h0, 4'h0, 64'h0, 64'h0);
        t.W_dstE = 4'h4; t.W_valE = 64'h200;
        add(t, 64'h200, 64'h200, 4'h4, F, 4'h4, 4'h4);
        // jXX
        t = mk(4'h7, 4'h1, 4'h1, 64'h50, 64'h99);
        add(t, 64'h99, 64'h0, F, F, F, F);
        // pushq r2
        t = mk(4'hA, 4'h2, 4'hF, 64'h0, 64'h0);
        add(t, 64'h5, 64'h200, 4'h4, F, 4'h2, 4'h4);

        // reset with a live W write that must be ignored
        t = mk(4'h6, 4'h3, 4'h1, 64'h0, 64'h0);
        t.W_dstE = 4'h1; t.W_valE = 64'h99;
        apply(t);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_nop("reset");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #3;
            chk($sformatf("v%0d d_srcA", i), 64'(d_srcA), 64'(tbl[i].x_srcA));
            chk($sformatf("v%0d d_srcB", i), 64'(d_srcB), 64'(tbl[i].x_srcB));
            @(posedge clk); #1;
            if (tbl[i].bubble) begin
                chk_nop($sformatf("v%0d bubble", i));
            end else begin
                chk($sformatf("v%0d stat", i), 64'(E_stat), 64'(tbl[i].stat));
                chk($sformatf("v%0d icode", i), 64'(E_icode), 64'(tbl[i].icode));
                chk($sformatf("v%0d ifun", i), 64'(E_ifun), 64'(tbl[i].ifun));
                chk($sformatf("v%0d valC", i), E_valC, tbl[i].valc);
                chk($sformatf("v%0d valA", i), E_valA, tbl[i].x_valA);
                chk($sformatf("v%0d valB", i), E_valB, tbl[i].x_valB);
                chk($sformatf("v%0d dstE", i), 64'(E_dstE), 64'(tbl[i].x_dstE));
                chk($sformatf("v%0d dstM", i), 64'(E_dstM), 64'(tbl[i].x_dstM));
                chk($sformatf("v%0d srcA", i), 64'(E_srcA), 64'(tbl[i].x_srcA));
                chk($sformatf("v%0d srcB", i), 64'(E_srcB), 64'(tbl[i].x_srcB));
            end
        end

        // mid-program reset: bubble asserted too, W write to r2 ignored
        @(negedge clk);
        t = mk(4'h6, 4'h3, 4'h2, 64'h0, 64'h0);
        t.bubble = 1'b1;
        t.W_dstE = 4'h2; t.W_valE = 64'h77;
        apply(t);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_nop("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(4'h2, 4'h2, 4'h5, 64'h0, 64'h0));
        @(posedge clk); #1;
        chk("post reset r2", E_valA, 64'h0);
        @(negedge clk);
        t = mk(4'hA, 4'h6, 4'h0, 64'h0, 64'h0);
        t.W_dstE = 4'h4; t.W_valE = 64'h9;
        apply(t);
        @(posedge clk); #1;
        chk("post reset r6", E_valA, 64'h0);
        chk("post reset fwd rsp", E_valB, 64'h9);
        @(negedge clk);
        apply(mk(4'h2, 4'h4, 4'h5, 64'h0, 64'h0));
        @(posedge clk); #1;
        chk("post reset r4", E_valA, 64'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
